// File: rtl/eql_seq_ctrl_if.sv
// Bus bundle for the eql sequencing controller: compare flags in,
// mux/code/ack/channel status out. The controller takes the slave side.
interface eql_seq_ctrl_if #(
   parameter int NCH = 4
);
   localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0] eql;
   logic           cont_eql;
   logic [1:0]     cc_mux;
   logic [1:0]     uscite;
   logic           enable_count;
   logic           ackout;
   logic [SW-1:0]  ch_sel;
   logic           timeout;
   logic           busy;

   modport master (
      output eql, cont_eql,
      input  cc_mux, uscite, enable_count, ackout, ch_sel, timeout, busy
   );

   modport slave (
      input  eql, cont_eql,
      output cc_mux, uscite, enable_count, ackout, ch_sel, timeout, busy
   );
endinterface

// File: rtl/eql_seq_ctrl.sv
// eql_seq_ctrl: round-robin service sequencer over NCH compare-equal channels.
// Each cycle the flag of the selected channel (e = eql[ch_sel]) steers the
// FSM; all outputs are registered and move on the same edge as the state.
// Optional build macro EQL_TIMEOUT_EN adds a self-loop watchdog that forces
// the ERR state after TMO consecutive cycles parked in one waiting state.
//
// state  | meaning
// -------+----------------------------------------------------------
// INIT   | after reset, heads to WAIT on the next edge
// WAIT   | idle, sampling the selected channel
// ENIN   | channel flag seen high directly from WAIT, holding
// ENIN_W | flag dropped after ENIN, waiting for release then advance
// INTR   | flag went high after a low sample (interrupt path)
// INTR_1 | one low sample seen in WAIT, checking again
// INTR_W | flag dropped after INTR, waiting then advance
// ERR    | watchdog expiry (EQL_TIMEOUT_EN only), recovers to WAIT
module eql_seq_ctrl #(
   parameter int NCH = 4,
   parameter int TMO = 16
) (
   input logic           clock,
   input logic           reset,
   eql_seq_ctrl_if.slave bus
);
   localparam int SW = $clog2(NCH);

   if (NCH < 2 || TMO < 2) begin : g_param_check
      $error("eql_seq_ctrl: NCH and TMO must both be >= 2");
   end

   typedef enum logic [2:0] {
      S_INIT   = 3'b000,
      S_WAIT   = 3'b001,
      S_ENIN   = 3'b010,
      S_ENIN_W = 3'b011,
      S_INTR   = 3'b100,
      S_INTR_1 = 3'b101,
      S_INTR_W = 3'b110,
      S_ERR    = 3'b111
   } state_t;

   // Initialisers give the reset values at power-up, before any reset edge.
   state_t        state_q        = S_INIT;
   logic [1:0]    cc_mux_q       = '0;
   logic [1:0]    uscite_q       = '0;
   logic          enable_count_q = 1'b0;
   logic          ackout_q       = 1'b0;
   logic [SW-1:0] ch_sel_q       = '0;
   logic          timeout_q      = 1'b0;

   state_t        state_d;
   logic [1:0]    cc_mux_d;
   logic [1:0]    uscite_d;
   logic          ack_d;
   logic          timeout_d;
   logic          ch_adv;
   logic          e;

   assign e = bus.eql[ch_sel_q];

`ifdef EQL_TIMEOUT_EN
   localparam int CW = $clog2(TMO) + 1;

   logic [CW-1:0] tmo_cnt_q = '0;
   logic [CW-1:0] tmo_cnt_d;
   logic          tmo_hit;

   assign tmo_hit = (tmo_cnt_q == CW'(TMO - 1));
`endif

   // Next-state decode; ch_sel advances whenever a service round ends in WAIT.
   always_comb begin
      state_d = state_q;
      ch_adv  = 1'b0;
      case (state_q)
         S_INIT:   state_d = S_WAIT;
         S_WAIT:   state_d = e ? S_ENIN : S_INTR_1;
         S_INTR_1: state_d = e ? S_INTR : S_WAIT;
         S_ENIN:   state_d = e ? S_ENIN : S_ENIN_W;
         S_INTR:   state_d = e ? S_INTR : S_INTR_W;
         S_ENIN_W: if (!e) begin
            state_d = S_WAIT;
            ch_adv  = 1'b1;
         end
         S_INTR_W: if (!e) begin
            state_d = S_WAIT;
            ch_adv  = 1'b1;
         end
`ifdef EQL_TIMEOUT_EN
         S_ERR: begin
            state_d = S_WAIT;
            ch_adv  = 1'b1;
         end
`endif
         default:  state_d = S_INIT;
      endcase
`ifdef EQL_TIMEOUT_EN
      // Only the four holding states can self-loop, so a repeat means a hold.
      if (state_d == state_q && tmo_hit) begin
         state_d = S_ERR;
      end
`endif
   end

   // Output decode: mux/code follow the state being entered.
   always_comb begin
      cc_mux_d  = 2'b00;
      uscite_d  = 2'b00;
      timeout_d = 1'b0;
      case (state_d)
         S_WAIT:   begin cc_mux_d = 2'b01; uscite_d = 2'b01; end
         S_ENIN:   begin cc_mux_d = 2'b11; uscite_d = 2'b00; end
         S_ENIN_W: begin cc_mux_d = 2'b01; uscite_d = 2'b01; end
         S_INTR:   begin cc_mux_d = 2'b11; uscite_d = 2'b00; end
         S_INTR_1: begin cc_mux_d = 2'b10; uscite_d = 2'b01; end
         S_INTR_W: begin cc_mux_d = 2'b10; uscite_d = 2'b11; end
         S_ERR:    begin cc_mux_d = 2'b00; uscite_d = 2'b10; timeout_d = 1'b1; end
         default:  begin cc_mux_d = 2'b00; uscite_d = 2'b00; end
      endcase
      // Release of the ENIN flag is always acknowledged, counter or not.
      ack_d = (state_q == S_ENIN && state_d == S_ENIN_W) ? 1'b1 : !bus.cont_eql;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= S_INIT;
         cc_mux_q       <= 2'b00;
         uscite_q       <= 2'b00;
         enable_count_q <= 1'b0;
         ackout_q       <= 1'b0;
         ch_sel_q       <= '0;
         timeout_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cc_mux_q       <= cc_mux_d;
         uscite_q       <= uscite_d;
         enable_count_q <= ack_d;
         ackout_q       <= ack_d;
         timeout_q      <= timeout_d;
         if (ch_adv) begin
            ch_sel_q <= (ch_sel_q == SW'(NCH - 1)) ? '0 : ch_sel_q + SW'(1);
         end
      end
   end

`ifdef EQL_TIMEOUT_EN
   // Watchdog counts consecutive self-loops and clears on any state change.
   always_comb begin
      tmo_cnt_d = (state_d == state_q) ? tmo_cnt_q + CW'(1) : '0;
   end

   // Watchdog register.
   always_ff @(posedge clock) begin
      if (reset) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   assign bus.timeout = timeout_q;
`else
   assign bus.timeout = 1'b0;
`endif

   assign bus.cc_mux       = cc_mux_q;
   assign bus.uscite       = uscite_q;
   assign bus.enable_count = enable_count_q;
   assign bus.ackout       = ackout_q;
   assign bus.ch_sel       = ch_sel_q;
   assign bus.busy         = (state_q != S_INIT) && (state_q != S_WAIT);
endmodule

// File: tb/tb_eql_seq_ctrl.sv
// Bench for eql_seq_ctrl: directed sequences plus random eql/cont_eql/reset
// traffic, checked every cycle against a transition-table reference model.
module tb_eql_seq_ctrl;
   localparam int NCH = 4;
   localparam int TMO = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   eql_seq_ctrl_if #(.NCH(NCH)) bus ();

   eql_seq_ctrl #(.NCH(NCH), .TMO(TMO)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   // Reference tables indexed [state][e]; states use the code numbering
   // INIT0 WAIT1 ENIN2 ENIN_W3 INTR4 INTR_15 INTR_W6 ERR7.
   int nxt_tab [8][2] = '{'{1,1}, '{5,2}, '{3,2}, '{1,3}, '{6,4}, '{1,4}, '{1,6}, '{1,1}};
   int cc_tab  [8][2] = '{'{1,1}, '{2,3}, '{1,3}, '{1,1}, '{2,3}, '{1,3}, '{1,2}, '{1,1}};
   int us_tab  [8][2] = '{'{1,1}, '{1,0}, '{1,0}, '{1,1}, '{3,0}, '{1,0}, '{1,3}, '{1,1}};

   int m_st = 0, m_ch = 0, m_cnt = 0;
   int m_cc = 0, m_us = 0, m_ack = 0, m_en = 0, m_to = 0;

   logic [NCH-1:0] r_eq = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input logic rst, input logic [NCH-1:0] eq, input logic ce);
      int e, nx;
      if (rst) begin
         m_st = 0; m_ch = 0; m_cnt = 0;
         m_cc = 0; m_us = 0; m_ack = 0; m_en = 0; m_to = 0;
      end else begin
         e    = int'(eq[m_ch]);
         nx   = nxt_tab[m_st][e];
         m_cc = cc_tab[m_st][e];
         m_us = us_tab[m_st][e];
         m_to = 0;
         m_ack = (m_st == 2 && e == 0) ? 1 : int'(!ce);
         m_en  = m_ack;
`ifdef EQL_TIMEOUT_EN
         if (nx == m_st) begin
            if (m_cnt == TMO - 1) begin
               nx = 7; m_cc = 0; m_us = 2; m_to = 1; m_cnt = 0;
            end else begin
               m_cnt++;
            end
         end else begin
            m_cnt = 0;
         end
`endif
         if ((m_st == 3 || m_st == 6 || m_st == 7) && nx == 1) m_ch = (m_ch + 1) % NCH;
         m_st = nx;
      end
   endtask

   task automatic compare_all();
      chk("cc_mux",       bus.cc_mux,       m_cc);
      chk("uscite",       bus.uscite,       m_us);
      chk("ackout",       bus.ackout,       m_ack);
      chk("enable_count", bus.enable_count, m_en);
      chk("ch_sel",       bus.ch_sel,       m_ch);
      chk("timeout",      bus.timeout,      m_to);
      chk("busy",         bus.busy,         (m_st > 1) ? 1 : 0);
   endtask

   task automatic cyc(input logic r, input logic [NCH-1:0] eq, input logic ce);
      reset        = r;
      bus.eql      = eq;
      bus.cont_eql = ce;
      @(posedge clock);
      model_step(r, eq, ce);
      @(negedge clock);
      compare_all();
   endtask

   task automatic rand_cyc(input int rst_pct);
      if ($urandom_range(3, 0) == 0) r_eq = NCH'($urandom);
      cyc($urandom_range(99, 0) < rst_pct, r_eq, 1'($urandom));
   endtask

   task automatic run_until(input int target);
      for (int i = 0; i < 3000 && m_st != target; i++) rand_cyc(0);
      chk("reach_state", m_st, target);
   endtask

   initial begin
      int to_cnt;
      int exp_us [5] = '{1, 0, 0, 3, 1};
      logic [4:0] seq_e = 5'b00110;

      bus.eql      = '0;
      bus.cont_eql = 1'b1;
      #1;
      compare_all();

      cyc(1, '0, 1);
      cyc(1, '0, 1);

      // Idle loop with all flags low: INIT, WAIT, INTR_1, WAIT ...
      repeat (8) cyc(0, '0, 1);
      chk("idle_ch_sel", bus.ch_sel, 0);

      // ENIN path on channel 0.
      for (int i = 0; i < 4 && m_st != 1; i++) cyc(0, '0, 1);
      cyc(0, 4'b0001, 1);
      cyc(0, 4'b0001, 1);
      cyc(0, 4'b0000, 1);
      chk("enin_w_ack", bus.ackout, 1);
      cyc(0, 4'b0000, 1);
      chk("enin_adv_ch", bus.ch_sel, 1);

      // Walk to channel 3 in WAIT, then the interrupt path 0,1,1,0,0.
      for (int i = 0; i < 100 && !(m_st == 1 && m_ch == 3); i++)
         cyc(0, (m_st == 1 && m_ch != 3) ? '1 : '0, 1);
      chk("at_ch3", bus.ch_sel, 3);
      for (int i = 0; i < 5; i++) begin
         cyc(0, seq_e[i] ? 4'b1000 : 4'b0000, 1);
         chk("intr_uscite", bus.uscite, exp_us[i]);
      end
      chk("intr_wrap_ch", bus.ch_sel, 0);

      // Long hold from WAIT: watchdog expiry when enabled.
      to_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(0, '1, 1);
         if (bus.timeout === 1'b1) to_cnt++;
      end
`ifdef EQL_TIMEOUT_EN
      chk("timeout_pulses", to_cnt, 1);
`else
      chk("timeout_pulses", to_cnt, 0);
`endif

      // cont_eql toggling in the WAIT loop.
      for (int i = 0; i < 4 && m_st != 1; i++) cyc(0, '0, 1);
      for (int i = 0; i < 10; i++) cyc(0, '0, 1'(i % 2));

      // Reset from INTR_W (and ERR when present).
      run_until(6);
      cyc(1, r_eq, 1);
      cyc(0, '0, 1);
`ifdef EQL_TIMEOUT_EN
      run_until(7);
      cyc(1, r_eq, 0);
      cyc(0, '0, 0);
`endif

      // Random traffic with occasional resets.
      repeat (3000) rand_cyc(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/eql_seq_ctrl.md
EQL_SEQ_CTRL -- requirements
Module: eql_seq_ctrl

Interface
REQ-001 Parameter NCH, default 4, number of eql channels; SHALL be >= 2; SW = clog2(NCH).
REQ-002 Parameter TMO, default 16, timeout limit in cycles; SHALL be >= 2.
REQ-003 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 eql  in  NCH  per-channel compare-equal flags.
REQ-006 cont_eql  in  1  counter-equal flag.
REQ-007 cc_mux  out  2  registered mux control.
REQ-008 uscite  out  2  registered output code.
REQ-009 enable_count  out  1  registered count enable.
REQ-010 ackout  out  1  registered acknowledge.
REQ-011 ch_sel  out  SW  registered index of the channel being serviced.
REQ-012 timeout  out  1  registered one-cycle timeout pulse.
REQ-013 busy  out  1  combinational; 1 when state is not INIT and not WAIT.

Function
REQ-014 e SHALL equal eql[ch_sel], sampled on the current edge; every output SHALL update on the same edge as the state (1-cycle latency).
REQ-015 States: INIT=000, WAIT=001, ENIN=010, ENIN_W=011, INTR=100, INTR_1=101, INTR_W=110, ERR=111.
REQ-016 When not in reset, ackout and enable_count SHALL both be set to !cont_eql each cycle, except as REQ-020 overrides.
REQ-017 INIT -> WAIT unconditionally; cc_mux=01, uscite=01.
REQ-018 WAIT: if e=1 -> ENIN, cc_mux=11, uscite=00; if e=0 -> INTR_1, cc_mux=10, uscite=01.
REQ-019 INTR_1: if e=1 -> INTR, cc_mux=11, uscite=00; if e=0 -> WAIT, cc_mux=01, uscite=01, ch_sel unchanged.
REQ-020 ENIN: if e=1, stay, cc_mux=11, uscite=00; if e=0 -> ENIN_W, cc_mux=01, uscite=01, ackout=1, enable_count=1 regardless of cont_eql.
REQ-021 ENIN_W: if e=1, stay, cc_mux=01, uscite=01; if e=0 -> WAIT, cc_mux=01, uscite=01.
REQ-022 INTR: if e=1, stay, cc_mux=11, uscite=00; if e=0 -> INTR_W, cc_mux=10, uscite=11.
REQ-023 INTR_W: if e=1, stay, cc_mux=10, uscite=11; if e=0 -> WAIT, cc_mux=01, uscite=01.
REQ-024 ch_sel SHALL advance by 1 on every transition ENIN_W->WAIT, INTR_W->WAIT, or ERR->WAIT, wrapping NCH-1 -> 0; it SHALL hold otherwise.
REQ-025 ch_sel SHALL NOT change in the cycle e is sampled, so each sample uses the pre-edge ch_sel.

Reset
REQ-026 reset=1 at any edge SHALL force state=INIT, cc_mux=00, uscite=00, enable_count=0, ackout=0, ch_sel=0, timeout=0, and timeout counter=0.
REQ-027 Reset SHALL override all other activity, including mid-sequence and in ERR; no partial state survives.
REQ-028 Outputs SHALL also hold the REQ-026 values at power-up, before the first reset.

Configuration
REQ-029 Macro EQL_TIMEOUT_EN defined: a counter (width clog2(TMO)+1) SHALL count consecutive self-loop cycles in ENIN, ENIN_W, INTR or INTR_W.
REQ-030 The counter SHALL clear on any state change.
REQ-031 If a self-loop is taken with the counter equal to TMO-1, the state SHALL go to ERR instead, with cc_mux=00, uscite=10, timeout=1.
REQ-032 In ERR: e is ignored; the next state is WAIT with cc_mux=01, uscite=01, timeout=0, and ch_sel advances.
REQ-033 timeout SHALL be 0 in every cycle other than the ERR entry cycle.
REQ-034 Macro EQL_TIMEOUT_EN undefined: no counter and no ERR state; timeout SHALL be tied 0; self-loops are unbounded.

Verification
REQ-035 Reset, then NCH=4, eql=0000, cont_eql=1 -> INIT, WAIT, INTR_1, WAIT loop; ch_sel stays 0; ackout=0.
REQ-036 eql[0]=1 for 2 cycles then 0 -> WAIT->ENIN->ENIN->ENIN_W with ackout=enable_count=1 at ENIN_W entry; then WAIT with ch_sel=1.
REQ-037 INTR path on channel 3 (0,1,1,0,0 sequence) -> uscite 01,00,00,11,01; ch_sel wraps 3->0.
REQ-038 EQL_TIMEOUT_EN, TMO=4, eql[ch_sel] held 1 in ENIN -> ERR after 4 self-loops; timeout=1 for exactly one cycle; WAIT next; ch_sel+1.
REQ-039 Assert reset while in INTR_W and while in ERR -> all outputs take REQ-026 values at the next edge; INIT follows.
REQ-040 cont_eql toggled every cycle in the WAIT loop -> ackout and enable_count track !cont_eql with 1-cycle lag.
